// File: rtl/dcache_pkg.sv
// Shared types and field-width helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } dcache_state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_IDX_BITS   = 3;
  localparam int DEF_TAG_W      = DEF_ADDR_WIDTH - DEF_IDX_BITS - 2;

  // Bits left above the line index and the byte offset within a word.
  function automatic int tag_width(input int addr_width, input int idx_bits);
    return addr_width - idx_bits - 2;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: combinational read by index, clocked line write.
// Only valid bits are reset; tag and data are don't-care while invalid.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TAG_W      = DEF_TAG_W,
  parameter int IDX_BITS   = DEF_IDX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_BITS-1:0]   rd_idx_i,
  output logic                  rd_vld_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic [DATA_WIDTH-1:0] rd_dat_o,
  input  logic                  wr_en_i,
  input  logic                  set_vld_i,
  input  logic [IDX_BITS-1:0]   wr_idx_i,
  input  logic [TAG_W-1:0]      wr_tag_i,
  input  logic [DATA_WIDTH-1:0] wr_dat_i
);

  localparam int LINES = 1 << IDX_BITS;

  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [DATA_WIDTH-1:0] data_q [LINES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (wr_en_i && set_vld_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_dat_i;
    end
  end

  assign rd_vld_o = valid_q[rd_idx_i];
  assign rd_tag_o = tag_q[rd_idx_i];
  assign rd_dat_o = data_q[rd_idx_i];

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped write-through no-allocate cache: load hits in 0 cycles, misses/stores stall until mem_ack.
// Optional DCACHE_STATS_EN adds wrapping 32-bit hit_count/miss_count outputs.
module data_cache_ctrl
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int IDX_BITS   = DEF_IDX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int TAG_W = tag_width(ADDR_WIDTH, IDX_BITS);

  dcache_state_t         state_q;
  logic [ADDR_WIDTH-3:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  mem_req_q;
  logic                  mem_we_q;

  logic [IDX_BITS-1:0]   rd_idx;
  logic [TAG_W-1:0]      req_tag;
  logic                  line_vld;
  logic [TAG_W-1:0]      line_tag;
  logic [DATA_WIDTH-1:0] line_dat;
  logic                  hit;
  logic                  idle;
  logic                  load_hit;
  logic                  load_miss;
  logic                  wr_en;
  logic                  set_vld;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[1:0];

  // In IDLE the live CPU address is looked up; otherwise the latched one.
  always_comb begin
    rd_idx  = addr_q[IDX_BITS-1:0];
    req_tag = addr_q[ADDR_WIDTH-3:IDX_BITS];
    if (state_q == IDLE) begin
      rd_idx  = cpu_addr[IDX_BITS+1:2];
      req_tag = cpu_addr[ADDR_WIDTH-1:IDX_BITS+2];
    end
  end

  assign hit       = line_vld && (line_tag == req_tag);
  assign idle      = (state_q == IDLE);
  assign load_hit  = idle && cpu_req && !cpu_we && hit;
  assign load_miss = idle && cpu_req && !cpu_we && !hit;

  assign set_vld = (state_q == REFILL) && mem_ack;
  assign wr_en   = set_vld || ((state_q == WRITE) && mem_ack && hit);

  dcache_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .TAG_W      (TAG_W),
    .IDX_BITS   (IDX_BITS)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_idx_i  (rd_idx),
    .rd_vld_o  (line_vld),
    .rd_tag_o  (line_tag),
    .rd_dat_o  (line_dat),
    .wr_en_i   (wr_en),
    .set_vld_i (set_vld),
    .wr_idx_i  (addr_q[IDX_BITS-1:0]),
    .wr_tag_i  (addr_q[ADDR_WIDTH-3:IDX_BITS]),
    .wr_dat_i  ((state_q == REFILL) ? mem_rdata : wdata_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req && cpu_we) begin
            addr_q    <= cpu_addr[ADDR_WIDTH-1:2];
            wdata_q   <= cpu_wdata;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b1;
            state_q   <= WRITE;
          end else if (load_miss) begin
            addr_q    <= cpu_addr[ADDR_WIDTH-1:2];
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b0;
            state_q   <= REFILL;
          end
        end
        REFILL, WRITE: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = {addr_q, 2'b00};
  assign mem_wdata = wdata_q;

  // The ack cycle releases the stall so the CPU can retire in the same cycle.
  always_comb begin
    stall     = !mem_ack;
    cpu_rdata = '0;
    if (idle) begin
      stall = cpu_req && !load_hit;
      if (load_hit) cpu_rdata = line_dat;
    end else if ((state_q == REFILL) && mem_ack) begin
      cpu_rdata = mem_rdata;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  assign hit_cnt_d  = hit_cnt_q + 32'(load_hit);
  assign miss_cnt_d = miss_cnt_q + 32'(load_miss);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed bench for data_cache_ctrl: hand-computed vectors, memory side driven step by step.
module tb_data_cache_ctrl;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  data_cache_ctrl #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .IDX_BITS   (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tg, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tg, obs, exp);
    end
  endtask

  // Starts just after a rising edge; k = ack on the k-th mem_req cycle, 0 = expected hit.
  task automatic access(input string tg, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int k,
                        input logic [31:0] mrd, input logic [31:0] exp_rd);
    int stalls;
    stalls    = 0;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    @(negedge clk);
    check({tg, ".detect_mem_req"}, 32'(mem_req), 32'd0);
    check({tg, ".detect_rdata"}, cpu_rdata, (k == 0) ? exp_rd : 32'd0);
    if (stall) stalls++;
    for (int c = 1; c <= k; c++) begin
      @(posedge clk);
      #1;
      if (c == k) begin
        mem_ack   = 1'b1;
        mem_rdata = mrd;
      end
      @(negedge clk);
      check({tg, ".mem_req"}, 32'(mem_req), 32'd1);
      check({tg, ".mem_we"}, 32'(mem_we), 32'(we));
      check({tg, ".mem_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
      if (we) check({tg, ".mem_wdata"}, mem_wdata, wdata);
      if (stall) stalls++;
      if (c == k && !we) check({tg, ".ack_rdata"}, cpu_rdata, exp_rd);
    end
    check({tg, ".stall_cycles"}, 32'(stalls), 32'(k));
    @(posedge clk);
    #1;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
  endtask

  task automatic idle(input string tg, input int n);
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tg, ".idle_mem_req"}, 32'(mem_req), 32'd0);
      check({tg, ".idle_stall"}, 32'(stall), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst       = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 32'd0;
    cpu_wdata = 32'd0;
    mem_rdata = 32'd0;
    mem_ack   = 1'b0;

    #3;
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.mem_req", 32'(mem_req), 32'd0);
    check("rst.mem_we", 32'(mem_we), 32'd0);
    check("rst.mem_addr", mem_addr, 32'd0);
    check("rst.mem_wdata", mem_wdata, 32'd0);
    check("rst.rdata", cpu_rdata, 32'd0);
`ifdef DCACHE_STATS_EN
    check("rst.hit_count", hit_count, 32'd0);
    check("rst.miss_count", miss_count, 32'd0);
`endif
    #9;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Cold miss acked on the 3rd mem_req cycle, then a back-to-back reload hit.
    access("ld100_miss", 1'b0, 32'h100, 32'd0, 3, 32'hDEADBEEF, 32'hDEADBEEF);
    access("ld100_hit", 1'b0, 32'h100, 32'd0, 0, 32'd0, 32'hDEADBEEF);
    idle("gap1", 1);

    access("st100", 1'b1, 32'h100, 32'h55, 2, 32'd0, 32'd0);
    access("ld100_after_st", 1'b0, 32'h100, 32'd0, 0, 32'd0, 32'h55);

    // Store to an uncached word does not allocate.
    access("st204", 1'b1, 32'h204, 32'h1234, 1, 32'd0, 32'd0);
    access("ld204_miss", 1'b0, 32'h204, 32'd0, 2, 32'hCAFE0204, 32'hCAFE0204);
    access("ld204_hit", 1'b0, 32'h204, 32'd0, 0, 32'd0, 32'hCAFE0204);
    idle("gap2", 1);
`ifdef DCACHE_STATS_EN
    check("stats.miss_count", miss_count, 32'd2);
    check("stats.hit_count", hit_count, 32'd3);
`endif

    // Reset while a refill of 0x120 is outstanding.
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h120;
    @(negedge clk);
    check("rstmid.detect_stall", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rstmid.mem_req_before", 32'(mem_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rstmid.mem_req_after", 32'(mem_req), 32'd0);
    check("rstmid.rdata", cpu_rdata, 32'd0);
    cpu_req = 1'b0;
    #1;
    check("rstmid.stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD0BAD;
    @(negedge clk);
    check("stray_ack.mem_req", 32'(mem_req), 32'd0);
    check("stray_ack.stall", 32'(stall), 32'd0);
    check("stray_ack.rdata", cpu_rdata, 32'd0);
    @(posedge clk);
    #1;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
`ifdef DCACHE_STATS_EN
    check("rstmid.hit_count", hit_count, 32'd0);
    check("rstmid.miss_count", miss_count, 32'd0);
`endif

    // 0x100 and 0x120 share index 0: every access below misses until the last.
    access("cf_ld100_a", 1'b0, 32'h100, 32'd0, 1, 32'h11111111, 32'h11111111);
    access("cf_ld120", 1'b0, 32'h120, 32'd0, 2, 32'h22222222, 32'h22222222);
    access("cf_ld100_b", 1'b0, 32'h100, 32'd0, 1, 32'h33333333, 32'h33333333);
    access("cf_ld100_hit", 1'b0, 32'h100, 32'd0, 0, 32'd0, 32'h33333333);
    idle("tail", 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
